// File: rtl/vn_lut_share_ctrl.sv
// Load/serve controller for one shared VN IB-LUT LUTRAM: streams the table into the write port, then time-shares the read port.
// Define VN_LUT_SHARE_RR_EN for round-robin arbitration; otherwise the lowest requester index wins.
module vn_lut_share_ctrl #(
  parameter int MSG_BITWIDTH  = 3,
  parameter int ADDR_BITWIDTH = 6,
  parameter int VN_LOAD_CYCLE = 64,
  parameter int SHARE_NUM     = 5,
  parameter int ID_BITWIDTH   = 3
) (
  input  logic                               sys_clk,
  input  logic                               rst,
  input  logic                               load_start,
  input  logic [MSG_BITWIDTH-1:0]            wr_data_i,
  input  logic                               wr_valid_i,
  output logic                               wr_ready_o,
  output logic [MSG_BITWIDTH-1:0]            lut_in,
  output logic [ADDR_BITWIDTH-1:0]           write_addr,
  output logic                               we,
  output logic [ADDR_BITWIDTH-1:0]           read_addr0,
  input  logic [MSG_BITWIDTH-1:0]            lut_data0,
  input  logic [SHARE_NUM-1:0]               req_i,
  input  logic [SHARE_NUM*ADDR_BITWIDTH-1:0] req_addr_i,
  output logic [SHARE_NUM-1:0]               gnt_o,
  output logic [MSG_BITWIDTH-1:0]            rd_data_o,
  output logic                               rd_valid_o,
  output logic [ID_BITWIDTH-1:0]             rd_id_o,
  output logic                               lut_ready_o,
  output logic                               load_done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SERVE} state_e;

  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(VN_LOAD_CYCLE - 1);

  state_e                    state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]  cnt_q, cnt_d;
  logic                      beat;
  logic                      we_q;
  logic [MSG_BITWIDTH-1:0]   lut_in_q;
  logic [ADDR_BITWIDTH-1:0]  write_addr_q;
  logic [MSG_BITWIDTH-1:0]   rd_data_q;
  logic                      rd_valid_q;
  logic [ID_BITWIDTH-1:0]    rd_id_q;
  logic                      load_done_q;
  logic                      gnt_any;
  logic [ID_BITWIDTH-1:0]    gnt_idx;
  logic [ADDR_BITWIDTH-1:0]  rd_addr;

`ifdef VN_LUT_SHARE_RR_EN
  logic [ID_BITWIDTH-1:0]    ptr_q, ptr_d;
`endif

  // wr_ready_o is high exactly in LOAD, so a beat needs only the valid.
  assign beat = (state_q == LOAD) && wr_valid_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = SERVE;
      SERVE: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan from lowest to highest priority so the highest-priority request is written last.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    rd_addr = '0;
    if (state_q == SERVE) begin
      for (int i = SHARE_NUM - 1; i >= 0; i--) begin
`ifdef VN_LUT_SHARE_RR_EN
        cand = int'(ptr_q) + i;
        if (cand >= SHARE_NUM) cand = cand - SHARE_NUM;
`else
        cand = i;
`endif
        if (req_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_BITWIDTH'(cand);
          rd_addr = req_addr_i[cand*ADDR_BITWIDTH +: ADDR_BITWIDTH];
        end
      end
    end
  end

  for (genvar gi = 0; gi < SHARE_NUM; gi++) begin : g_gnt
    assign gnt_o[gi] = gnt_any && (gnt_idx == ID_BITWIDTH'(gi));
  end

`ifdef VN_LUT_SHARE_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (int'(gnt_idx) == SHARE_NUM - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      lut_in_q     <= '0;
      write_addr_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_id_q      <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= beat;
      if (beat) begin
        lut_in_q     <= wr_data_i;
        write_addr_q <= cnt_q;
      end
      load_done_q <= (state_q == DRAIN);
      rd_valid_q  <= gnt_any;
      if (gnt_any) begin
        rd_data_q <= lut_data0;
        rd_id_q   <= gnt_idx;
      end
    end
  end

  assign wr_ready_o  = (state_q == LOAD);
  assign lut_ready_o = (state_q == SERVE);
  assign load_done_o = load_done_q;
  assign we          = we_q;
  assign lut_in      = lut_in_q;
  assign write_addr  = write_addr_q;
  assign read_addr0  = rd_addr;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_id_o     = rd_id_q;

endmodule

// File: tb/tb_vn_lut_share_ctrl.sv
// Directed bench for vn_lut_share_ctrl with a behavioural async-read LUTRAM attached.
module tb_vn_lut_share_ctrl;
  localparam int MW = 3;
  localparam int AW = 6;
  localparam int LC = 64;
  localparam int SN = 5;
  localparam int IW = 3;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_start = 1'b0;
  logic [MW-1:0]    wr_data_i = '0;
  logic             wr_valid_i = 1'b0;
  logic             wr_ready_o;
  logic [MW-1:0]    lut_in;
  logic [AW-1:0]    write_addr;
  logic             we;
  logic [AW-1:0]    read_addr0;
  logic [MW-1:0]    lut_data0;
  logic [SN-1:0]    req_i = '0;
  logic [SN*AW-1:0] req_addr_i = '0;
  logic [SN-1:0]    gnt_o;
  logic [MW-1:0]    rd_data_o;
  logic             rd_valid_o;
  logic [IW-1:0]    rd_id_o;
  logic             lut_ready_o;
  logic             load_done_o;

  int total = 0;
  int bad = 0;
  int nwr = 0;
  int wr_bad = 0;
  int addr_tab [SN];
  logic [MW-1:0] mem [2**AW];

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (we) mem[write_addr] <= lut_in;
  end
  assign lut_data0 = mem[read_addr0];

  vn_lut_share_ctrl #(
    .MSG_BITWIDTH(MW), .ADDR_BITWIDTH(AW), .VN_LOAD_CYCLE(LC),
    .SHARE_NUM(SN), .ID_BITWIDTH(IW)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .load_start(load_start),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .lut_in(lut_in), .write_addr(write_addr), .we(we),
    .read_addr0(read_addr0), .lut_data0(lut_data0),
    .req_i(req_i), .req_addr_i(req_addr_i), .gnt_o(gnt_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_id_o(rd_id_o),
    .lut_ready_o(lut_ready_o), .load_done_o(load_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge sys_clk); #1;
    load_start = 1'b0;
  endtask

  // Streams n beats (optionally valid on every other cycle) and logs the write port.
  task automatic stream(input int n, input bit gap);
    int  sent;
    int  cyc;
    bit  v;
    bit  acc;
    sent = 0; cyc = 0; nwr = 0; wr_bad = 0;
    while (sent < n && cyc < 1000) begin
      v = !gap || (cyc % 2 == 0);
      wr_valid_i = v;
      wr_data_i  = MW'(sent % 8);
      acc = v && wr_ready_o;
      @(posedge sys_clk); #1;
      if (acc) sent++;
      cyc++;
      if (we) begin
        if (write_addr !== AW'(nwr) || lut_in !== MW'(nwr % 8)) wr_bad++;
        nwr++;
      end
    end
    wr_valid_i = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    chk({tag, "_nwr"}, nwr, LC);
    chk({tag, "_wrseq"}, wr_bad, 0);
    chk({tag, "_drain_rdy"}, wr_ready_o, 0);
    chk({tag, "_drain_lutrdy"}, lut_ready_o, 0);
    chk({tag, "_drain_done"}, load_done_o, 0);
    @(posedge sys_clk); #1;
    chk({tag, "_done_pulse"}, load_done_o, 1);
    chk({tag, "_lut_ready"}, lut_ready_o, 1);
    chk({tag, "_we_off"}, we, 0);
    chk({tag, "_serve_rdy"}, wr_ready_o, 0);
    @(posedge sys_clk); #1;
    chk({tag, "_done_single"}, load_done_o, 0);
    chk({tag, "_lut_ready2"}, lut_ready_o, 1);
  endtask

  task automatic serve_cycle(input logic [SN-1:0] req, input logic [SN-1:0] exp_gnt, input bit ld);
    int k;
    k = -1;
    for (int i = 0; i < SN; i++) if (exp_gnt[i]) k = i;
    req_i = req;
    load_start = ld;
    #1;
    chk("gnt", gnt_o, exp_gnt);
    if (k >= 0) chk("raddr", read_addr0, addr_tab[k]);
    @(posedge sys_clk); #1;
    load_start = 1'b0;
    chk("rvalid", rd_valid_o, (k >= 0) ? 1 : 0);
    if (k >= 0) begin
      chk("rid", rd_id_o, k);
      chk("rdata", rd_data_o, addr_tab[k] % 8);
    end
  endtask

  initial begin
    logic [SN-1:0] exp_g;
    for (int k = 0; k < SN; k++) begin
      addr_tab[k] = k * 7 + 3;
      req_addr_i[k*AW +: AW] = AW'(addr_tab[k]);
    end

    // Reset values
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_we", we, 0);
    chk("rst_lut_in", lut_in, 0);
    chk("rst_waddr", write_addr, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_raddr", read_addr0, 0);
    chk("rst_rdata", rd_data_o, 0);
    chk("rst_rvalid", rd_valid_o, 0);
    chk("rst_rid", rd_id_o, 0);
    chk("rst_lut_ready", lut_ready_o, 0);
    chk("rst_done", load_done_o, 0);
    rst = 1'b0;
    req_i = 5'b11111;
    @(posedge sys_clk); #1;
    chk("idle_rdy", wr_ready_o, 0);
    chk("idle_gnt", gnt_o, 0);

    // Back-to-back load
    start_load();
    chk("load_rdy", wr_ready_o, 1);
    chk("load_gnt", gnt_o, 0);
    chk("load_raddr", read_addr0, 0);
    req_i = '0;
    stream(LC, 1'b0);
    finish_load("ld1");

    // Reload from SERVE with gapped valid
    start_load();
    chk("reload_rdy", wr_ready_o, 1);
    stream(LC, 1'b1);
    finish_load("ld2");

    // All requesters held for 10 cycles
    for (int c = 0; c < 10; c++) begin
`ifdef VN_LUT_SHARE_RR_EN
      exp_g = SN'(1) << (c % SN);
`else
      exp_g = 5'b00001;
`endif
      serve_cycle(5'b11111, exp_g, 1'b0);
    end

    // Sparse requests: 2 and 4
`ifdef VN_LUT_SHARE_RR_EN
    serve_cycle(5'b10100, 5'b00100, 1'b0);
    serve_cycle(5'b10100, 5'b10000, 1'b0);
    serve_cycle(5'b10100, 5'b00100, 1'b0);
`else
    serve_cycle(5'b10100, 5'b00100, 1'b0);
    serve_cycle(5'b10100, 5'b00100, 1'b0);
    serve_cycle(5'b10100, 5'b00100, 1'b0);
`endif
    serve_cycle(5'b00000, 5'b00000, 1'b0);

    // load_start in SERVE while requester 2 waits
    serve_cycle(5'b00100, 5'b00100, 1'b1);
    chk("ls_load_rdy", wr_ready_o, 1);
    chk("ls_lut_ready", lut_ready_o, 0);
    #1;
    chk("ls_gnt_off", gnt_o, 0);
    chk("ls_raddr_off", read_addr0, 0);
    req_i = '0;
    stream(LC, 1'b0);
    finish_load("ld3");

    // Reset after 30 beats
    start_load();
    stream(30, 1'b0);
    chk("part_nwr", nwr, 30);
    chk("part_wrseq", wr_bad, 0);
    rst = 1'b1;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    chk("mrst_we", we, 0);
    chk("mrst_rdy", wr_ready_o, 0);
    chk("mrst_lut_ready", lut_ready_o, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge sys_clk); #1;
      chk("mrst_no_done", load_done_o, 0);
      chk("mrst_no_ready", lut_ready_o, 0);
    end
    start_load();
    stream(LC, 1'b0);
    finish_load("ld4");
    serve_cycle(5'b11111, 5'b00001, 1'b0);
    serve_cycle(5'b01000, 5'b01000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vn_lut_share_ctrl.md
# vn_lut_share_ctrl

Controller for one shared VN IB-LUT memory cell: the asynchronous-read LUTRAM instance with `lut_data0`, `read_addr0`, `lut_in`, `write_addr` and `we`.
- First loads `VN_LOAD_CYCLE` LUT entries from a valid/ready stream into the write port.
- Then time-shares the single read port among `SHARE_NUM` variable-node requesters, one grant per cycle.
- Sits between the LUT-configuration loader and the VN processing units of a sharing group.

## Interface
Parameters:
- `MSG_BITWIDTH`, default 3: LUT entry / message width.
- `ADDR_BITWIDTH`, default 6: LUT address width.
- `VN_LOAD_CYCLE`, default 64: number of entries loaded. Must satisfy 1 ≤ `VN_LOAD_CYCLE` ≤ 2^`ADDR_BITWIDTH`.
- `SHARE_NUM`, default 5: number of read requesters, 2..8.
- `ID_BITWIDTH`, default 3: requester index width, ≥ clog2(`SHARE_NUM`).

Ports:
- `sys_clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `load_start`, in, 1: pulse that starts a (re)load.
- `wr_data_i`, in, `MSG_BITWIDTH`: load stream data.
- `wr_valid_i`, in, 1: load stream valid.
- `wr_ready_o`, out, 1: load stream ready.
- `lut_in`, out, `MSG_BITWIDTH`: LUTRAM write data.
- `write_addr`, out, `ADDR_BITWIDTH`: LUTRAM write address.
- `we`, out, 1: LUTRAM write enable.
- `read_addr0`, out, `ADDR_BITWIDTH`: LUTRAM read address.
- `lut_data0`, in, `MSG_BITWIDTH`: LUTRAM asynchronous read data.
- `req_i`, in, `SHARE_NUM`: per-requester read request.
- `req_addr_i`, in, `SHARE_NUM*ADDR_BITWIDTH`: per-requester address; requester k occupies slice [k*`ADDR_BITWIDTH` +: `ADDR_BITWIDTH`].
- `gnt_o`, out, `SHARE_NUM`: one-hot grant, combinational.
- `rd_data_o`, out, `MSG_BITWIDTH`: registered read data.
- `rd_valid_o`, out, 1: `rd_data_o` is valid.
- `rd_id_o`, out, `ID_BITWIDTH`: index of the requester that owns `rd_data_o`.
- `lut_ready_o`, out, 1: high while the FSM is in SERVE.
- `load_done_o`, out, 1: one-cycle pulse on entry to SERVE.

## Operation
FSM states: IDLE, LOAD, DRAIN, SERVE.
- IDLE: `load_start` → LOAD.
- LOAD: `wr_ready_o`=1.
  - Each beat (`wr_valid_i`&`wr_ready_o`) registers `lut_in`=`wr_data_i`, `write_addr`=cnt and `we`=1 for the following cycle, then increments cnt.
  - The beat accepted at cnt=`VN_LOAD_CYCLE`-1 → DRAIN.
  - Cycles with no beat leave `we`=0.
- DRAIN: `wr_ready_o`=0; the final write commits. Next cycle → SERVE.
- SERVE: `lut_ready_o`=1; arbitration is active.
  - `load_start` in SERVE → LOAD next cycle. The grant issued in the `load_start` cycle completes normally.
  - Memory contents are undefined until the next `load_done_o`.
- `load_start` in LOAD or DRAIN is ignored.
- cnt clears to 0 on every entry to LOAD.

Arbitration, SERVE only:
- Round-robin pointer `ptr`. The grant goes to the first k with `req_i[k]`=1, searching ptr, ptr+1, … modulo `SHARE_NUM`.
- `read_addr0` = `req_addr_i` slice of the granted k.
- After a grant to k, ptr ← (k+1) mod `SHARE_NUM`. With no request, ptr holds.
- Outside SERVE: `gnt_o`=0 and `read_addr0`=0.
- Requesters hold `req_i` until granted. A grant consumes exactly one request-cycle.

## Timing
- Reset values: `wr_ready_o`=0, `we`=0, `lut_in`=0, `write_addr`=0, `gnt_o`=0, `read_addr0`=0, `rd_data_o`=0, `rd_valid_o`=0, `rd_id_o`=0, `lut_ready_o`=0, `load_done_o`=0; ptr=0, cnt=0, state=IDLE.
- Write latency: accepted beat at cycle t → `we`/`write_addr`/`lut_in` asserted in cycle t+1.
- Read latency: grant at cycle t (combinational `gnt_o`, `read_addr0`) → `rd_data_o`=`lut_data0` sampled at the end of t; `rd_valid_o`=1 and `rd_id_o`=k in t+1.
- `rd_valid_o` deasserts the cycle after a no-grant cycle. Throughput is one read per cycle.
- Minimum load time: `VN_LOAD_CYCLE` accepted beats + 1 DRAIN cycle. `load_done_o` is high in the first SERVE cycle.
- Reset mid-load: next cycle is IDLE with `we`=0. The partial load is abandoned and `lut_ready_o` stays 0.

## Configuration
- `VN_LUT_SHARE_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest index wins.
  - ptr is removed and is effectively constant 0.
  - All other behaviour is unchanged.

## Test plan
- Reset, then `load_start`, then 64 consecutive beats with data = addr mod 8 → `we` pulses 64 times at addresses 0..63; DRAIN for 1 cycle; `load_done_o` pulses once; `lut_ready_o`=1.
- Load with `wr_valid_i` toggling every other cycle → 64 writes, no skipped or duplicated address, `wr_ready_o`=0 from DRAIN onward.
- SERVE with `req_i`=5'b11111 held for 10 cycles, RR enabled → grant order 0,1,2,3,4,0,1,2,3,4; each `rd_id_o` matches one cycle later and `rd_data_o` = loaded value at that requester's address.
- Same stimulus with `VN_LUT_SHARE_RR_EN` undefined → requester 0 granted every cycle.
- `load_start` in SERVE while `req_i[2]`=1 → that cycle's grant completes (`rd_valid_o` next cycle); `gnt_o`=0 afterwards; cnt restarts at 0.
- Assert `rst` after 30 load beats → IDLE, `we`=0 next cycle, no `load_done_o`; a fresh load then succeeds.
